mult_unit: RTL and testbench
============================

MULT_UNIT -- requirements
Module: mult_unit

Interface
REQ-001 SHALL have parameter WORD_LENGTH, default 32, operand and result-half width.
REQ-002 SHALL have parameter COUNT_LENGTH, default CeilLog(WORD_LENGTH)+1, step-counter width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request a multiply; sampled only when ready=1.
REQ-006 SHALL have port is_signed  input  1  1 = two's-complement (MULT), 0 = unsigned (MULTU); sampled with start.
REQ-007 SHALL have port multiplicand  input  WORD_LENGTH  operand A, driven from register file read_data_1.
REQ-008 SHALL have port multiplier  input  WORD_LENGTH  operand B, driven from register file read_data_2.
REQ-009 SHALL have port ready  output  1  high only in IDLE; unit accepts start.
REQ-010 SHALL have port done  output  1  one-cycle pulse; hi/lo hold the new product.
REQ-011 SHALL have port hi  output  WORD_LENGTH  upper product half (MFHI source).
REQ-012 SHALL have port lo  output  WORD_LENGTH  lower product half (MFLO source).

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 SHALL, in IDLE with start=1, latch |A| and |B| (magnitudes if is_signed=1, raw otherwise), latch sign flag = is_signed & (A[MSB] ^ B[MSB]), clear accumulator and counter, and go to RUN.
REQ-015 SHALL, in IDLE with start=0, stay in IDLE with all registers held.
REQ-016 SHALL, each RUN cycle, perform one radix-2 shift-add step: if multiplier LSB=1 add multiplicand into upper accumulator half with carry, then shift the 2*WORD_LENGTH+1-bit accumulator/multiplier right by one; counter increments.
REQ-017 SHALL leave RUN after exactly WORD_LENGTH steps, writing hi/lo on that same edge (negated 2*WORD_LENGTH-bit product if sign flag=1), and enter DONE.
REQ-018 SHALL assert done=1 for exactly the single DONE cycle, then return to IDLE unconditionally.
REQ-019 SHALL give latency: start sampled at edge N -> done high during cycle after edge N+WORD_LENGTH -> ready high after edge N+WORD_LENGTH+1.
REQ-020 SHALL ignore start while in RUN or DONE; operands and is_signed changes during RUN have no effect.
REQ-021 SHALL hold hi/lo stable from one DONE to the next; they change only on the RUN->DONE edge.
REQ-022 SHALL produce correct results for boundary operands: 0, all-ones, most-negative value (0x80000000 signed, magnitude 2^31 handled without overflow).
REQ-023 SHALL accept a start asserted in the first IDLE cycle after DONE (back-to-back, no dead cycle beyond DONE).

Reset
REQ-024 SHALL, on reset=0 at any time including mid-RUN, asynchronously force state IDLE, ready=1, done=0, hi=0, lo=0, counter=0, accumulator=0; partial result discarded.
REQ-025 SHALL resume normal operation on the first rising clk edge after reset deasserts.

Structure
REQ-026 SHALL place the state encoding constants, WORD_LENGTH default and CeilLog function in the shared package used by register-file-adjacent blocks.
REQ-027 SHALL build hi and lo from two instances of the existing Register sub-module, enable driven by the RUN->DONE transition; no other sub-module.
REQ-028 SHALL contain no combinational multiplier operator; datapath is one WORD_LENGTH+1-bit adder.

Verification
REQ-029 Unsigned: A=0x00000003, B=0x00000005, is_signed=0 -> done 32 cycles after start edge, hi=0x00000000, lo=0x0000000F.
REQ-030 Signed: A=0xFFFFFFFE (-2), B=0x00000007, is_signed=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFF2; same operands unsigned -> hi=0x00000006, lo=0xFFFFFFF2.
REQ-031 Extremes: A=B=0x80000000 signed -> hi=0x40000000, lo=0; A=B=0xFFFFFFFF unsigned -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-032 Busy rejection: start held high throughout a multiply with operands changed at cycle 10 -> result reflects original operands; second operation begins only after DONE.
REQ-033 Reset mid-op: reset=0 at RUN step 16 -> same cycle ready=1, done=0, hi=lo=0; no done pulse follows.
REQ-034 Back-to-back: start in first IDLE cycle after done -> second done exactly WORD_LENGTH+2 cycles after first done; first hi/lo held until second DONE.

Source files
------------

// File: rtl/mult_unit_pkg.sv
// Shared definitions for the multiply unit and the register-file-adjacent blocks
// that reuse its state encoding and width helpers.
package mult_unit_pkg;

  localparam int unsigned WORD_LENGTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned ceil_log(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/mult_unit_register.sv
// Enabled register with asynchronous active-low clear; holds one product half.
module mult_unit_register #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      q <= '0;
    else if (enable) q <= d;
  end

endmodule

// File: rtl/mult_unit.sv
// Sequential radix-2 shift-add multiplier (MULT/MULTU), one step per clock,
// signed operation via magnitudes plus a final conditional negation.
module mult_unit
  import mult_unit_pkg::*;
#(
  parameter int unsigned WORD_LENGTH  = WORD_LENGTH_DEFAULT,
  parameter int unsigned COUNT_LENGTH = ceil_log(WORD_LENGTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   is_signed,
  input  logic [WORD_LENGTH-1:0] multiplicand,
  input  logic [WORD_LENGTH-1:0] multiplier,
  output logic                   ready,
  output logic                   done,
  output logic [WORD_LENGTH-1:0] hi,
  output logic [WORD_LENGTH-1:0] lo
);

  state_t state, state_next;

  logic [WORD_LENGTH-1:0]    mcand_q;
  logic [2*WORD_LENGTH:0]    acc_q, acc_next;
  logic [WORD_LENGTH:0]      sum;
  logic [COUNT_LENGTH-1:0]   count_q;
  logic                      sign_q;
  logic                      last_step, load_result;
  logic [WORD_LENGTH-1:0]    mag_a, mag_b;
  logic [2*WORD_LENGTH-1:0]  product, result;

  // The most-negative operand negates to itself; read unsigned it is the
  // correct magnitude 2^(W-1), so no extra bit is needed.
  assign mag_a = (is_signed && multiplicand[WORD_LENGTH-1]) ? -multiplicand : multiplicand;
  assign mag_b = (is_signed && multiplier[WORD_LENGTH-1])   ? -multiplier   : multiplier;

  always_comb begin
    sum      = acc_q[2*WORD_LENGTH:WORD_LENGTH]
             + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_next = {sum, acc_q[WORD_LENGTH-1:0]} >> 1;
    product  = acc_next[2*WORD_LENGTH-1:0];
    result   = sign_q ? -product : product;
  end

  assign last_step   = (count_q == COUNT_LENGTH'(WORD_LENGTH - 1));
  assign load_result = (state == RUN) && last_step;
  assign ready       = (state == IDLE);
  assign done        = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand_q <= '0;
      acc_q   <= '0;
      count_q <= '0;
      sign_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mcand_q <= mag_a;
          acc_q   <= {{(WORD_LENGTH+1){1'b0}}, mag_b};
          count_q <= '0;
          sign_q  <= is_signed & (multiplicand[WORD_LENGTH-1] ^ multiplier[WORD_LENGTH-1]);
        end
        RUN: begin
          acc_q   <= acc_next;
          count_q <= count_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  mult_unit_register #(.WIDTH(WORD_LENGTH)) u_hi (
    .clk    (clk),
    .reset  (reset),
    .enable (load_result),
    .d      (result[2*WORD_LENGTH-1:WORD_LENGTH]),
    .q      (hi)
  );

  mult_unit_register #(.WIDTH(WORD_LENGTH)) u_lo (
    .clk    (clk),
    .reset  (reset),
    .enable (load_result),
    .d      (result[WORD_LENGTH-1:0]),
    .q      (lo)
  );

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: directed boundary vectors, random operands,
// busy rejection, mid-operation reset and back-to-back operation.
module tb_mult_unit;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          is_signed;
  logic [W-1:0]  multiplicand;
  logic [W-1:0]  multiplier;
  logic          ready;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int checks = 0;
  int errors = 0;

  mult_unit #(.WORD_LENGTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .is_signed    (is_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .ready        (ready),
    .done         (done),
    .hi           (hi),
    .lo           (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic sg);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub;
    if (sg) begin
      sa = $signed({{32{a[W-1]}}, a});
      sb = $signed({{32{b[W-1]}}, b});
      return sa * sb;
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sg);
    int lat;
    check({tag, "_ready"}, 64'(ready), 64'd1);
    multiplicand = a;
    multiplier   = b;
    is_signed    = sg;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
    is_signed    = 1'($urandom);
    wait_done(lat);
    check({tag, "_lat"}, 64'(lat), 64'(W));
    check({tag, "_prod"}, {hi, lo}, model(a, b, sg));
    tick();
    check({tag, "_idle"}, {62'd0, ready, done}, 64'b10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, gap;
    int saw_ready, saw_done, held_bad;
    logic [W-1:0] a1, b1, a2, b2;
    logic sg2;
    logic [63:0] r1;

    reset = 1'b0; start = 1'b0; is_signed = 1'b0;
    multiplicand = '0; multiplier = '0;
    #1;
    check("reset_state", {ready, done, hi, lo}, {1'b1, 1'b0, 64'd0});
    tick(); tick();
    reset = 1'b1;
    tick();
    check("post_reset", {ready, done, hi, lo}, {1'b1, 1'b0, 64'd0});

    run_op("u3x5",     32'h0000_0003, 32'h0000_0005, 1'b0);
    check("u3x5_exact", {hi, lo}, 64'h0000_0000_0000_000F);
    run_op("s_m2x7",   32'hFFFF_FFFE, 32'h0000_0007, 1'b1);
    check("s_m2x7_exact", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF2);
    run_op("u_m2x7",   32'hFFFF_FFFE, 32'h0000_0007, 1'b0);
    check("u_m2x7_exact", {hi, lo}, 64'h0000_0006_FFFF_FFF2);
    run_op("s_min2",   32'h8000_0000, 32'h8000_0000, 1'b1);
    check("s_min2_exact", {hi, lo}, 64'h4000_0000_0000_0000);
    run_op("u_ones2",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("u_ones2_exact", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("s_ones2",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_op("s_minx1",  32'h8000_0000, 32'h0000_0001, 1'b1);
    run_op("s_zero",   32'h0000_0000, 32'h8765_4321, 1'b1);
    run_op("u_zero",   32'hDEAD_BEEF, 32'h0000_0000, 1'b0);

    for (int i = 0; i < 24; i++) begin
      run_op($sformatf("rand%0d", i), $urandom, $urandom, 1'($urandom));
    end

    // Busy rejection: start held high, operands changed mid-run.
    a1 = $urandom | 32'h1; b1 = $urandom | 32'h1;
    a2 = $urandom | 32'h1; b2 = $urandom | 32'h1; sg2 = 1'($urandom);
    multiplicand = a1; multiplier = b1; is_signed = 1'b1; start = 1'b1;
    tick();
    lat = 0; saw_ready = 0;
    while (!done && lat < 200) begin
      if (ready) saw_ready++;
      tick();
      lat++;
      if (lat == 10) begin
        multiplicand = a2; multiplier = b2; is_signed = sg2;
      end
    end
    check("busy_lat", 64'(lat), 64'(W));
    check("busy_noready", 64'(saw_ready), 64'd0);
    check("busy_prod", {hi, lo}, model(a1, b1, 1'b1));
    tick();
    check("busy_idle", {62'd0, ready, done}, 64'b10);
    tick();
    start = 1'b0;
    check("busy_second_started", 64'(ready), 64'd0);
    wait_done(lat);
    check("busy_second_lat", 64'(lat), 64'(W));
    check("busy_second_prod", {hi, lo}, model(a2, b2, sg2));
    tick();

    // Reset during RUN after 16 steps.
    run_op("pre_rst", 32'h0000_0007, 32'h0000_0009, 1'b0);
    multiplicand = 32'h1234_5678; multiplier = 32'h9ABC_DEF0; is_signed = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (16) tick();
    #1;
    reset = 1'b0;
    #1;
    check("midrst_outputs", {ready, done, hi, lo}, {1'b1, 1'b0, 64'd0});
    tick();
    reset = 1'b1;
    saw_done = 0;
    for (int i = 0; i < W + 5; i++) begin
      tick();
      if (done) saw_done++;
    end
    check("midrst_no_done", 64'(saw_done), 64'd0);
    check("midrst_hold", {hi, lo}, 64'd0);
    run_op("post_rst", 32'hFFFF_FFF0, 32'h0000_0010, 1'b1);

    // Back-to-back: second start in the first IDLE cycle after DONE.
    a1 = $urandom; b1 = $urandom;
    a2 = $urandom; b2 = $urandom; sg2 = 1'($urandom);
    r1 = model(a1, b1, 1'b0);
    multiplicand = a1; multiplier = b1; is_signed = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat);
    check("b2b_first_prod", {hi, lo}, r1);
    multiplicand = a2; multiplier = b2; is_signed = sg2; start = 1'b1;
    tick();
    gap = 1;
    check("b2b_idle_ready", 64'(ready), 64'd1);
    tick();
    gap++;
    start = 1'b0;
    held_bad = 0;
    while (!done && gap < 200) begin
      if ({hi, lo} !== r1) held_bad++;
      tick();
      gap++;
    end
    check("b2b_gap", 64'(gap), 64'(W + 2));
    check("b2b_held", 64'(held_bad), 64'd0);
    check("b2b_second_prod", {hi, lo}, model(a2, b2, sg2));
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
